// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register (hold, serial shift,
// rotate, arithmetic shift, parallel load, clear) with a burst engine that
// performs a programmed number of consecutive shifts from one start request.
//
// Optional feature macro: UNIV_SHIFT_REG_PARITY_EN
//   defined     -> parity = ^q
//   not defined -> parity tied low (port kept)

module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [LW-1:0]    burst_len,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeShr   = 3'b001;
    localparam logic [2:0] ModeShl   = 3'b010;
    localparam logic [2:0] ModeLoad  = 3'b011;
    localparam logic [2:0] ModeRor   = 3'b100;
    localparam logic [2:0] ModeRol   = 3'b101;
    localparam logic [2:0] ModeAsr   = 3'b110;
    localparam logic [2:0] ModeClear = 3'b111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bmode_q, bmode_d;

    logic             burst_mode;
    logic             start_burst;
    logic             start_empty;
    logic             last_shift;
    logic [LW-1:0]    len_clamped;

    // Next register value for a given operation.
    function automatic logic [WIDTH-1:0] shift_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             sir,
        input logic             sil,
        input logic [WIDTH-1:0] pin
    );
        logic [WIDTH-1:0] res;
        res = cur;
        unique case (op)
            ModeHold:  res = cur;
            ModeShr:   res = {sir, cur[WIDTH-1:1]};
            ModeShl:   res = {cur[WIDTH-2:0], sil};
            ModeLoad:  res = pin;
            ModeRor:   res = {cur[0], cur[WIDTH-1:1]};
            ModeRol:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            ModeAsr:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            ModeClear: res = '0;
            default:   res = cur;
        endcase
        return res;
    endfunction

    // Decode start request: only shift/rotate modes can launch a burst.
    always_comb begin
        unique case (mode)
            ModeShr, ModeShl, ModeRor, ModeRol, ModeAsr: burst_mode = 1'b1;
            default:                                     burst_mode = 1'b0;
        endcase
        // Non-burst modes take precedence: start with hold/load/clear is a plain op
        start_burst = start && burst_mode && (burst_len != '0);
        start_empty = start && burst_mode && (burst_len == '0);
        last_shift  = (cnt_q == LW'(1));
        len_clamped = (burst_len > LW'(WIDTH)) ? LW'(WIDTH) : burst_len;
    end

    // State register; en low freezes the FSM.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_burst) begin
                    state_d = StBurst;
                end else if (start_empty) begin
                    state_d = StDone;
                end
            end
            StBurst: begin
                if (last_shift) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == StBurst);
        done = (state_q == StDone);
    end

    // Datapath next values: register, burst counter, latched burst mode.
    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        bmode_d = bmode_q;
        unique case (state_q)
            StIdle: begin
                if (start_burst) begin
                    // Accepting edge leaves q untouched
                    bmode_d = mode;
                    cnt_d   = len_clamped;
                end else if (!start_empty) begin
                    q_d = shift_op(mode, q_q, serial_in_r, serial_in_l, par_in);
                end
            end
            StBurst: begin
                q_d   = shift_op(bmode_q, q_q, serial_in_r, serial_in_l, par_in);
                cnt_d = cnt_q - LW'(1);
            end
            StDone: begin
                q_d = shift_op(mode, q_q, serial_in_r, serial_in_l, par_in);
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    // Datapath registers; en low holds everything.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            cnt_q   <= '0;
            bmode_q <= ModeHold;
        end else if (en) begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            bmode_q <= bmode_d;
        end
    end

    // Combinational views of the register.
    always_comb begin
        q            = q_q;
        serial_out_r = q_q[0];
        serial_out_l = q_q[WIDTH-1];
`ifdef UNIV_SHIFT_REG_PARITY_EN
        parity       = ^q_q;
`else
        parity       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed steps from the
// test plan followed by randomized cycles, all checked against a small
// arithmetic reference model.

module tb_univ_shift_reg;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic       serial_in_r;
    logic       serial_in_l;
    logic [7:0] par_in;
    logic       start;
    logic [3:0] burst_len;
    logic [7:0] q;
    logic       serial_out_r;
    logic       serial_out_l;
    logic       busy;
    logic       done;
    logic       parity;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_q;
    int         m_pending;
    bit         m_done;
    logic [2:0] m_bmode;

    univ_shift_reg #(.WIDTH(8), .LW(4)) dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .serial_in_r  (serial_in_r),
        .serial_in_l  (serial_in_l),
        .par_in       (par_in),
        .start        (start),
        .burst_len    (burst_len),
        .q            (q),
        .serial_out_r (serial_out_r),
        .serial_out_l (serial_out_l),
        .busy         (busy),
        .done         (done),
        .parity       (parity)
    );

    always #5 clk_2 = ~clk_2;

    function automatic logic [7:0] model_op(input logic [2:0] md, input logic [7:0] v,
                                            input logic sr, input logic sl,
                                            input logic [7:0] p);
        int u;
        u = int'(v);
        case (md)
            3'd0:    return v;
            3'd1:    return 8'((u / 2) + (sr ? 128 : 0));
            3'd2:    return 8'(((u * 2) % 256) + (sl ? 1 : 0));
            3'd3:    return p;
            3'd4:    return 8'((u / 2) + (u % 2) * 128);
            3'd5:    return 8'(((u * 2) % 256) + (u / 128));
            3'd6:    return 8'((u / 2) + (u / 128) * 128);
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_q       = 8'h00;
        m_pending = 0;
        m_done    = 1'b0;
        m_bmode   = 3'd0;
    endtask

    // One enabled clock edge of the reference behaviour.
    task automatic model_step(input logic [2:0] md, input logic sr, input logic sl,
                              input logic [7:0] p, input logic st, input logic [3:0] bl);
        bit shift_md;
        shift_md = (md == 3'd1) || (md == 3'd2) || (md == 3'd4) || (md == 3'd5) ||
                   (md == 3'd6);
        if (m_pending > 0) begin
            m_q = model_op(m_bmode, m_q, sr, sl, p);
            m_pending--;
            if (m_pending == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_q    = model_op(md, m_q, sr, sl, p);
            m_done = 1'b0;
        end else if (st && shift_md) begin
            if (bl == 4'd0) begin
                m_done = 1'b1;
            end else begin
                m_pending = (int'(bl) > 8) ? 8 : int'(bl);
                m_bmode   = md;
            end
        end else begin
            m_q = model_op(md, m_q, sr, sl, p);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_par;
`ifdef UNIV_SHIFT_REG_PARITY_EN
        exp_par = ^m_q;
`else
        exp_par = 1'b0;
`endif
        check({tag, ".q"}, 32'(q), 32'(m_q));
        check({tag, ".busy"}, 32'(busy), 32'(m_pending > 0));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".sor"}, 32'(serial_out_r), 32'(m_q[0]));
        check({tag, ".sol"}, 32'(serial_out_l), 32'(m_q[7]));
        check({tag, ".parity"}, 32'(parity), 32'(exp_par));
    endtask

    // Drive inputs, take one clock edge, update model, check #1 after the edge.
    task automatic cyc(input string tag, input logic e, input logic [2:0] md, input logic sr,
                       input logic sl, input logic [7:0] p, input logic st,
                       input logic [3:0] bl);
        en          = e;
        mode        = md;
        serial_in_r = sr;
        serial_in_l = sl;
        par_in      = p;
        start       = st;
        burst_len   = bl;
        @(posedge clk_2);
        if (e) model_step(md, sr, sl, p, st, bl);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check({tag, ".q0"}, 32'(q), 32'h0);
        check({tag, ".busy0"}, 32'(busy), 32'h0);
        check({tag, ".done0"}, 32'(done), 32'h0);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 3'd0; serial_in_r = 1'b0; serial_in_l = 1'b0;
        par_in = 8'h00; start = 1'b0; burst_len = 4'd0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk_2);
        reset = 1'b0;

        // Reset between edges after a load
        cyc("load_a5", 1, 3'd3, 0, 0, 8'hA5, 0, 0);
        check("load_a5.val", 32'(q), 32'hA5);
        async_reset("rst_mid");
        check_all("rst_mid");

        // Single operations
        cyc("load_96", 1, 3'd3, 0, 0, 8'h96, 0, 0);
        cyc("rol", 1, 3'd5, 0, 0, 8'h00, 0, 0);
        check("rol.val", 32'(q), 32'h2D);
        cyc("load_80", 1, 3'd3, 0, 0, 8'h80, 0, 0);
        cyc("asr", 1, 3'd6, 0, 0, 8'h00, 0, 0);
        check("asr.val", 32'(q), 32'hC0);
        cyc("load_01", 1, 3'd3, 0, 0, 8'h01, 0, 0);
        cyc("shl", 1, 3'd2, 0, 1, 8'h00, 0, 0);
        check("shl.val", 32'(q), 32'h03);
        cyc("clear", 1, 3'd7, 0, 0, 8'h00, 0, 0);
        check("clear.val", 32'(q), 32'h00);

        // Burst of 3 rotate-rights from 0x81
        cyc("load_81", 1, 3'd3, 0, 0, 8'h81, 0, 0);
        cyc("ror_acc", 1, 3'd4, 0, 0, 8'h00, 1, 4'd3);
        check("ror_acc.busy", 32'(busy), 32'h1);
        check("ror_acc.q", 32'(q), 32'h81);
        for (int i = 0; i < 3; i++) cyc("ror_run", 1, 3'd0, 0, 0, 8'h00, 0, 0);
        check("ror.val", 32'(q), 32'h30);
        check("ror.done", 32'(done), 32'h1);
        cyc("ror_post", 1, 3'd0, 0, 0, 8'h00, 0, 0);
        check("ror_post.done", 32'(done), 32'h0);

        // Clamp 12 -> 8 and lockout of start/load during BURST
        cyc("clr2", 1, 3'd7, 0, 0, 8'h00, 0, 0);
        cyc("clamp_acc", 1, 3'd1, 1, 0, 8'h00, 1, 4'd12);
        for (int i = 0; i < 8; i++) cyc("clamp_run", 1, 3'd3, 1, 0, 8'h55, 1, 4'd12);
        check("clamp.val", 32'(q), 32'hFF);
        check("clamp.done", 32'(done), 32'h1);
        cyc("clamp_post", 1, 3'd0, 0, 0, 8'h00, 0, 0);

        // Zero-length burst
        cyc("len0", 1, 3'd1, 0, 0, 8'h00, 1, 4'd0);
        check("len0.done", 32'(done), 32'h1);
        check("len0.q", 32'(q), 32'hFF);
        cyc("len0_post", 1, 3'd0, 0, 0, 8'h00, 0, 0);

        // en low mid-burst freezes everything
        cyc("clr3", 1, 3'd7, 0, 0, 8'h00, 0, 0);
        cyc("en_acc", 1, 3'd2, 0, 1, 8'h00, 1, 4'd5);
        for (int i = 0; i < 2; i++) cyc("en_run", 1, 3'd0, 0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) cyc("en_frz", 0, 3'd3, 0, 1, 8'hAA, 1, 4'd1);
        check("en_frz.q", 32'(q), 32'h03);
        check("en_frz.busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) cyc("en_res", 1, 3'd0, 0, 1, 8'h00, 0, 0);
        check("en_res.val", 32'(q), 32'h1F);
        check("en_res.done", 32'(done), 32'h1);
        cyc("en_post", 1, 3'd0, 0, 0, 8'h00, 0, 0);

        // Parity
        cyc("load_07", 1, 3'd3, 0, 0, 8'h07, 0, 0);
`ifdef UNIV_SHIFT_REG_PARITY_EN
        check("parity07", 32'(parity), 32'h1);
`else
        check("parity07", 32'(parity), 32'h0);
`endif

        // Reset during a burst aborts without a done pulse
        cyc("rb_acc", 1, 3'd4, 0, 0, 8'h00, 1, 4'd6);
        cyc("rb_run", 1, 3'd0, 0, 0, 8'h00, 0, 0);
        async_reset("rst_burst");
        cyc("rb_after", 1, 3'd0, 0, 0, 8'h00, 0, 0);

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
